// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts an 8-bit switch pattern out one bit per clk_2, MSB- or LSB-first,
// single-shot or repeating, with LED status and a bits-remaining 7-segment digit.
module serial_pattern_tx #(
    parameter int NBITS_DATA = 8,
    parameter int NBITS_CNT  = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NBITS_DATA-1:0] data_in,
    input  logic                  lsb_first,
    input  logic                  repeat_en,
    output logic                  bit_out,
    output logic                  busy,
    output logic                  done,
    output logic [NBITS_CNT-1:0]  bits_left,
    output logic [7:0]            seg
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam logic [NBITS_CNT-1:0] FULL = NBITS_CNT'(NBITS_DATA);
    state_t state, state_nxt;
    logic [NBITS_DATA-1:0] shreg, shreg_nxt, held, held_nxt;
    logic [NBITS_CNT-1:0] cnt_nxt;
    logic order, order_nxt, last;
    logic [3:0] nib;
    logic [6:0] hex;
    assign last = bits_left == NBITS_CNT'(1);
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            held      <= '0;
            order     <= 1'b0;
            bits_left <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            held      <= held_nxt;
            order     <= order_nxt;
            bits_left <= cnt_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        held_nxt  = held;
        order_nxt = order;
        cnt_nxt   = bits_left;
        unique case (state)
            IDLE: if (start) begin
                state_nxt = SEND;
                shreg_nxt = data_in;
                held_nxt  = data_in;
                order_nxt = lsb_first;
                cnt_nxt   = FULL;
            end
            SEND: if (!last) begin
                shreg_nxt = order ? shreg >> 1 : shreg << 1;
                cnt_nxt   = bits_left - NBITS_CNT'(1);
            end else if (repeat_en) begin
                // back-to-back reload from the held copy keeps the stream gapless
                shreg_nxt = held;
                cnt_nxt   = FULL;
            end else begin
                state_nxt = DONE;
                cnt_nxt   = '0;
            end
            DONE: state_nxt = start ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    assign busy    = state == SEND;
    assign done    = state == DONE;
    assign bit_out = busy & (order ? shreg[0] : shreg[NBITS_DATA-1]);
    assign nib     = 4'(bits_left);
    always_comb begin
        hex = 7'h3F;
        case (nib)
            4'h0: hex = 7'h3F;
            4'h1: hex = 7'h06;
            4'h2: hex = 7'h5B;
            4'h3: hex = 7'h4F;
            4'h4: hex = 7'h66;
            4'h5: hex = 7'h6D;
            4'h6: hex = 7'h7D;
            4'h7: hex = 7'h07;
            4'h8: hex = 7'h7F;
            4'h9: hex = 7'h6F;
            4'hA: hex = 7'h77;
            4'hB: hex = 7'h7C;
            4'hC: hex = 7'h39;
            4'hD: hex = 7'h5E;
            4'hE: hex = 7'h79;
            default: hex = 7'h71;
        endcase
    end
    assign seg = {busy, hex};
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed-vector bench for serial_pattern_tx with hand-computed expectations.
module tb_serial_pattern_tx;
    logic clk_2 = 1'b0, reset, start, lsb_first, repeat_en;
    logic [7:0] data_in;
    logic bit_out, busy, done;
    logic [3:0] bits_left;
    logic [7:0] seg;
    int errors = 0, checks = 0;

    serial_pattern_tx dut (
        .clk_2(clk_2), .reset(reset), .start(start), .data_in(data_in),
        .lsb_first(lsb_first), .repeat_en(repeat_en), .bit_out(bit_out),
        .busy(busy), .done(done), .bits_left(bits_left), .seg(seg)
    );

    always #5 clk_2 = ~clk_2;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic b4_msb [8] = '{1, 0, 1, 1, 0, 1, 0, 0};
    logic b4_lsb [8] = '{0, 0, 1, 0, 1, 1, 0, 1};
    logic e0_msb [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    logic [7:0] seg_send [8] = '{8'hFF, 8'h87, 8'hFD, 8'hED, 8'hE6, 8'hCF, 8'hDB, 8'h86};

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic bo, input logic bz, input logic dn,
                             input logic [3:0] bl, input logic [7:0] sg);
        chk({tag, ".bit_out"}, 32'(bit_out), 32'(bo));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".bits_left"}, 32'(bits_left), 32'(bl));
        chk({tag, ".seg"}, 32'(seg), 32'(sg));
    endtask

    initial begin
        // 1: reset with start held high
        reset = 1; start = 1; data_in = 8'hB4; lsb_first = 0; repeat_en = 0;
        step();
        check_out("rst1", 0, 0, 0, 0, 8'h3F);
        step();
        check_out("rst2", 0, 0, 0, 0, 8'h3F);
        // 2: single MSB-first frame of 0xB4 with start held
        reset = 0;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            check_out($sformatf("msb%0d", i), b4_msb[i], 1, 0, 4'(8 - i), seg_send[i]);
        end
        step();
        check_out("msb_done", 0, 0, 1, 0, 8'h3F);
        step();
        check_out("msb_hold1", 0, 0, 1, 0, 8'h3F);
        step();
        check_out("msb_hold2", 0, 0, 1, 0, 8'h3F);
        start = 0;
        step();
        check_out("msb_idle", 0, 0, 0, 0, 8'h3F);
        step();
        check_out("msb_idle2", 0, 0, 0, 0, 8'h3F);
        // 3: LSB-first, data_in disturbed mid-frame
        lsb_first = 1; start = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            check_out($sformatf("lsb%0d", i), b4_lsb[i], 1, 0, 4'(8 - i), seg_send[i]);
            if (i == 1) begin data_in = 8'hFF; lsb_first = 0; end
        end
        step();
        check_out("lsb_done", 0, 0, 1, 0, 8'h3F);
        start = 0;
        step();
        check_out("lsb_idle", 0, 0, 0, 0, 8'h3F);
        // 4: repeat mode with 0xE0, repeat dropped in the second frame
        data_in = 8'hE0; lsb_first = 0; repeat_en = 1; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            check_out($sformatf("rep%0d", i), e0_msb[i % 8], 1, 0, 4'(8 - i % 8), seg_send[i % 8]);
            if (i == 10) repeat_en = 0;
        end
        step();
        check_out("rep_done", 0, 0, 1, 0, 8'h3F);
        step();
        check_out("rep_idle", 0, 0, 0, 0, 8'h3F);
        // 5: reset during bit 4, then a full fresh frame
        data_in = 8'hB4; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check_out($sformatf("pre%0d", i), b4_msb[i], 1, 0, 4'(8 - i), seg_send[i]);
        end
        reset = 1;
        step();
        check_out("midrst", 0, 0, 0, 0, 8'h3F);
        reset = 0;
        step();
        check_out("midrst_idle", 0, 0, 0, 0, 8'h3F);
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            check_out($sformatf("post%0d", i), b4_msb[i], 1, 0, 4'(8 - i), seg_send[i]);
        end
        step();
        check_out("post_done", 0, 0, 1, 0, 8'h3F);
        step();
        check_out("post_idle", 0, 0, 0, 0, 8'h3F);
        // 6: start held in DONE never retriggers; low then high restarts
        start = 1;
        step();
        for (int i = 0; i < 8; i++) step();
        check_out("d6_done", 0, 0, 1, 0, 8'h3F);
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("d6_hold%0d", k), 0, 0, 1, 0, 8'h3F);
        end
        start = 0;
        step();
        check_out("d6_idle", 0, 0, 0, 0, 8'h3F);
        start = 1; data_in = 8'h80;
        step();
        check_out("d6_first", 1, 1, 0, 8, 8'hFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
